// File: rtl/seq_op_pkg.sv
// Shared state encoding and step codes for the seq_op_controller sequencer.
package seq_op_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    XOR  = 3'd2,
    OR   = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [1:0] STEP_IDLE = 2'd0;
  localparam logic [1:0] STEP_LOAD = 2'd1;
  localparam logic [1:0] STEP_XOR  = 2'd2;
  localparam logic [1:0] STEP_OR   = 2'd3;

  // DONE reports the idle step code.
  function automatic logic [1:0] step_of(state_e s);
    logic [1:0] r;
    r = STEP_IDLE;
    case (s)
      LOAD:    r = STEP_LOAD;
      XOR:     r = STEP_XOR;
      OR:      r = STEP_OR;
      default: r = STEP_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_op_step_alu.sv
// Combinational accumulator update for one sequencer step (LOAD, XOR or OR).
module seq_op_step_alu
  import seq_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0]       step_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] acc_o
);

  always_comb begin
    acc_o = acc_i;
    case (step_i)
      STEP_LOAD: acc_o = a_i;
      STEP_XOR:  acc_o = acc_i ^ b_i;
      STEP_OR:   acc_o = acc_i | c_i;
      default:   acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/seq_op_controller.sv
// Multi-cycle sequencer computing x = (a ^ b) | c one registered step per clock.
// Optional SEQ_OP_COMB_CHECK_EN adds a 'mismatch' output checking the result against the full expression.
module seq_op_controller
  import seq_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             skip_xor,
  input  logic             skip_or,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x,
`ifdef SEQ_OP_COMB_CHECK_EN
  output logic             mismatch,
`endif
  output logic [1:0]       step
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, x_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic             skip_xor_q, skip_or_q;
  logic             ready_q, busy_q, done_q;
  logic [1:0]       step_q;
  logic             enter_done;

  seq_op_step_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .step_i(step_q),
    .acc_i (acc_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .c_i   (c_q),
    .acc_o (acc_d)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = !skip_xor_q ? XOR : (!skip_or_q ? OR : DONE);
      XOR:     state_d = !skip_or_q ? OR : DONE;
      OR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_done = (state_d == DONE) && (state_q != DONE);

`ifdef SEQ_OP_COMB_CHECK_EN
  logic mismatch_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else if (enter_done) begin
      mismatch_q <= (acc_d != ((a_q ^ b_q) | c_q));
    end
  end
  assign mismatch = mismatch_q;
`endif

  // Status outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      x_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      skip_xor_q <= 1'b0;
      skip_or_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      step_q     <= STEP_IDLE;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (state_q == IDLE && start) begin
        a_q        <= a;
        b_q        <= b;
        c_q        <= c;
        skip_xor_q <= skip_xor;
        skip_or_q  <= skip_or;
      end
      if (enter_done) x_q <= acc_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d == LOAD) || (state_d == XOR) || (state_d == OR);
      done_q  <= (state_d == DONE);
      step_q  <= step_of(state_d);
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign x     = x_q;
  assign step  = step_q;

endmodule

// File: doc/seq_op_controller.md
Name: seq_op_controller

Overview:
- Multi-cycle sequencer for the a/b/c logic datapath.
- Captures operands on a start handshake, then applies LOAD, XOR and OR to a single accumulator, one step per clock.
- The final result is (a ^ b) | c, built explicitly in registered stages, so no combinational feedback is ever created.
- Sits between a requester issuing start pulses and any consumer of the result x.

Parameters:
WIDTH, 8, bit width of operands a, b, c, the accumulator and x.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
start  input  1  request. Accepted only when ready=1.
a  input  WIDTH  operand loaded into the accumulator.
b  input  WIDTH  XOR operand.
c  input  WIDTH  OR operand.
skip_xor  input  1  omit the XOR step. Captured at accept.
skip_or  input  1  omit the OR step. Captured at accept.
ready  output  1  high only in IDLE.
busy  output  1  high in LOAD, XOR and OR.
done  output  1  one-cycle pulse in the DONE state.
x  output  WIDTH  registered result; holds the last completed value.
step  output  2  current step: 0=idle/done, 1=load, 2=xor, 3=or.

Behaviour:
- Reset (synchronous):
  - state=IDLE.
  - acc, x, captured operands and captured skip flags all cleared to 0.
  - ready=1, busy=0, done=0, step=0.
- States and transitions:
  - IDLE: start=1 at an edge captures a, b, c, skip_xor, skip_or into internal registers; next state LOAD. Otherwise stay in IDLE.
  - LOAD: acc <= a_q. Next state XOR if !skip_xor_q, else OR if !skip_or_q, else DONE.
  - XOR: acc <= acc ^ b_q. Next state OR if !skip_or_q, else DONE.
  - OR: acc <= acc | c_q. Next state DONE.
  - On the edge entering DONE, x <= the final accumulator value, including the operation applied on that same edge.
  - DONE: done=1 for exactly one cycle; next state IDLE.
- Latency, counted from the accepting edge to the done cycle:
  - 4 cycles with no skips.
  - 3 cycles with one step skipped.
  - 2 cycles with both skipped.
- Minimum start-to-start spacing is latency+1 cycles. Back-to-back accept in the DONE cycle is not allowed (ready=0 there).
- start while not in IDLE: ignored, not queued.
- Input changes after accept: a, b, c and skip flags may change freely. Only captured values are used.
- x changes only on the DONE-entry edge or on reset. Between runs it holds the previous result.
- rst has priority over every transition, including mid-operation:
  - No done pulse for the aborted run.
  - x cleared to 0.
- Outputs ready, busy, done and step decode from registered state only. No combinational path from inputs to outputs.
- All bitwise operations are WIDTH-wide. No carries, no truncation.

Optional Feature:
- Macro: SEQ_OP_COMB_CHECK_EN.
- When defined:
  - Adds output `mismatch` (1 bit, reset 0).
  - On the DONE-entry edge, mismatch <= (final acc != ((a_q ^ b_q) | c_q)), comparing against the full expression regardless of skips.
  - Held until the next DONE entry or reset.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package seq_op_pkg:
  - state encoding localparams IDLE, LOAD, XOR, OR, DONE;
  - step code constants STEP_IDLE, STEP_LOAD, STEP_XOR, STEP_OR.
- One natural sub-module: seq_op_step_alu.
  - Combinational; inputs step, acc, a_q, b_q, c_q; output is the next accumulator value.
  - Keeps the controller as the FSM plus registers.

Test Plan:
1. WIDTH=8, a=0x0F, b=0xFF, c=0x00, no skips, start for 1 cycle -> busy for 3 cycles, done 4 cycles after the accepting edge, x=0xF0, step sequence 1,2,3,0.
2. a=0xA5, b=0x5A, c=0x0F, skip_xor=1 -> done 3 cycles after accept, x=0xAF. The XOR step (step=2) never appears.
3. a=0x3C, skip_xor=1, skip_or=1 -> done 2 cycles after accept, x=0x3C.
4. start held high continuously; a/b/c changed to 0xFF every cycle after accept; first operands a=0x01, b=0x03, c=0x10 -> exactly one done per run with x=0x12; the next accept occurs only when ready=1.
5. rst pulsed for 1 cycle while step=2 -> next cycle ready=1, busy=0, x=0x00; no done pulse; a subsequent run completes normally.
6. With SEQ_OP_COMB_CHECK_EN defined:
   - a=0x00, b=0x00, c=0x01, skip_or=1 -> x=0x00, mismatch=1.
   - Rerun with no skips -> x=0x01, mismatch=0.
